// File: rtl/photon_pkg.sv
// Shared sizing, header layout and word addressing for the photon frame packer.
package photon_pkg;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned SLOTS   = 255;
    localparam int unsigned FRAME_W = 8192;
    localparam int unsigned SYNC_N  = 3;
    localparam int unsigned SLOT_W  = 8;
    localparam int unsigned SEQ_W   = 16;

    localparam logic [15:0]      HDR_MAGIC = 16'hA5C3;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef struct packed {
        logic [15:0]      magic;
        logic [SEQ_W-1:0] seq;
    } hdr_t;

    // LSB position of word k inside a frame; word 0 occupies the top bits.
    function automatic int unsigned word_lsb(input int unsigned k);
        return FRAME_W - CNT_W * (k + 1);
    endfunction

endpackage

// File: rtl/photon_frame_packer_if.sv
// Detector/SPI-side signal bundle between the packer and its environment.
interface photon_frame_packer_if;
    import photon_pkg::*;

    logic                photon;
    logic                gate;
    logic                SS;
    logic [FRAME_W-1:0]  tx;
    logic                frame_rdy;
    logic [SLOT_W-1:0]   slot_idx;
    logic                ovf;
    logic                sat;

    modport master (
        output photon, gate, SS,
        input  tx, frame_rdy, slot_idx, ovf, sat
    );

    modport slave (
        input  photon, gate, SS,
        output tx, frame_rdy, slot_idx, ovf, sat
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on its last two stages.
module sync_edge #(
    parameter int unsigned SYNC_N = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    // bit 0 is the newest sample, bit SYNC_N-1 the oldest
    logic [SYNC_N-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], i_async};
        end
    end

    assign o_level  = r_sync[SYNC_N-2];
    assign o_rise_c =  r_sync[SYNC_N-2] & ~r_sync[SYNC_N-1];
    assign o_fall_c = ~r_sync[SYNC_N-2] &  r_sync[SYNC_N-1];

endmodule

// File: rtl/photon_frame_packer.sv
// Counts photons per gate window, packs 255 counts plus header into a frame, and
// publishes completed frames onto the SPI tx vector only while slave select is idle.
module photon_frame_packer
    import photon_pkg::*;
(
    input  logic                  sysClk,
    input  logic                  rst_n,
    photon_frame_packer_if.slave  bus
);

    localparam int unsigned PAY_W = FRAME_W - CNT_W;
    localparam int unsigned LSB_W = $clog2(PAY_W);

    localparam logic [0:0] ST_FILL     = 1'b0;
    localparam logic [0:0] ST_COMPLETE = 1'b1;
    localparam logic [0:0] PUB_IDLE    = 1'b0;
    localparam logic [0:0] PUB_WAIT_SS = 1'b1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    logic w_ph_lvl, w_ph_rise, w_ph_fall;
    logic w_gate_lvl, w_gate_rise, w_gate_fall;
    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_unused_sync;

    logic [0:0]         r_fsm, w_fsm_nxt;
    logic [0:0]         r_pub, w_pub_nxt;
    logic [CNT_W-1:0]   r_count, w_cnt_nxt, w_cnt_inc;
    logic               w_sat_hit;
    logic [SLOT_W-1:0]  r_slot_idx;
    logic [SEQ_W-1:0]   r_seq;
    logic [PAY_W-1:0]   r_shadow;
    logic [FRAME_W-1:0] r_pend, r_tx, w_new_frame;
    logic               r_frame_rdy, r_ovf, r_sat;
    logic               w_pub_ok, w_close_frame;
    logic               w_load_tx, w_tx_from_new, w_load_pend, w_set_ovf;
    logic [LSB_W-1:0]   w_slot_lsb;
    hdr_t               w_hdr;

    sync_edge #(.SYNC_N(SYNC_N)) u_sync_photon (
        .clk(sysClk), .rst_n(rst_n), .i_async(bus.photon),
        .o_level(w_ph_lvl), .o_rise_c(w_ph_rise), .o_fall_c(w_ph_fall)
    );

    sync_edge #(.SYNC_N(SYNC_N)) u_sync_gate (
        .clk(sysClk), .rst_n(rst_n), .i_async(bus.gate),
        .o_level(w_gate_lvl), .o_rise_c(w_gate_rise), .o_fall_c(w_gate_fall)
    );

    sync_edge #(.SYNC_N(SYNC_N)) u_sync_ss (
        .clk(sysClk), .rst_n(rst_n), .i_async(bus.SS),
        .o_level(w_ss_lvl), .o_rise_c(w_ss_rise), .o_fall_c(w_ss_fall)
    );

    assign w_unused_sync = ^{w_ph_lvl, w_ph_fall, w_ss_rise};

    // Saturating photon counter; the falling-edge cycle still counts a coincident photon.
    assign w_cnt_inc = (r_count == CNT_MAX) ? CNT_MAX : r_count + CNT_W'(1);

    always_comb begin
        w_cnt_nxt = r_count;
        w_sat_hit = 1'b0;
        if (w_gate_rise) begin
            w_cnt_nxt = CNT_W'(w_ph_rise);
        end else if ((w_gate_lvl || w_gate_fall) && w_ph_rise) begin
            w_cnt_nxt = w_cnt_inc;
            w_sat_hit = (r_count == CNT_MAX);
        end
    end

    assign w_slot_lsb  = LSB_W'(word_lsb(32'(r_slot_idx) + 32'd1));
    assign w_hdr       = '{magic: HDR_MAGIC, seq: r_seq};
    assign w_new_frame = {w_hdr, r_shadow};
    assign w_pub_ok    = w_ss_lvl & ~w_ss_fall;

    // Next state for the frame FSM and the publish FSM, plus their datapath strobes.
    always_comb begin
        w_fsm_nxt     = r_fsm;
        w_pub_nxt     = r_pub;
        w_load_tx     = 1'b0;
        w_tx_from_new = 1'b0;
        w_load_pend   = 1'b0;
        w_set_ovf     = 1'b0;
        w_close_frame = w_gate_fall && (r_slot_idx == LAST_SLOT);

        case (r_fsm)
            ST_FILL:     if (w_close_frame) w_fsm_nxt = ST_COMPLETE;
            ST_COMPLETE: w_fsm_nxt = ST_FILL;
            default:     w_fsm_nxt = ST_FILL;
        endcase

        if (r_fsm == ST_COMPLETE) begin
            w_set_ovf = (r_pub == PUB_WAIT_SS);
            if (w_pub_ok) begin
                w_load_tx     = 1'b1;
                w_tx_from_new = 1'b1;
                w_pub_nxt     = PUB_IDLE;
            end else begin
                w_load_pend = 1'b1;
                w_pub_nxt   = PUB_WAIT_SS;
            end
        end else if ((r_pub == PUB_WAIT_SS) && w_pub_ok) begin
            w_load_tx = 1'b1;
            w_pub_nxt = PUB_IDLE;
        end
    end

    always_ff @(posedge sysClk) begin
        if (!rst_n) begin
            r_fsm <= ST_FILL;
            r_pub <= PUB_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
            r_pub <= w_pub_nxt;
        end
    end

    always_ff @(posedge sysClk) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_ovf       <= 1'b0;
            r_slot_idx  <= '0;
            r_seq       <= '0;
            r_shadow    <= '0;
            r_pend      <= '0;
            r_tx        <= '0;
            r_frame_rdy <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            if (w_sat_hit) r_sat <= 1'b1;
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_gate_fall) begin
                r_shadow[w_slot_lsb +: CNT_W] <= w_cnt_nxt;
                r_slot_idx <= (r_slot_idx == LAST_SLOT) ? '0 : r_slot_idx + SLOT_W'(1);
            end
            if (r_fsm == ST_COMPLETE) r_seq <= r_seq + SEQ_W'(1);
            if (w_load_pend) r_pend <= w_new_frame;
            if (w_load_tx) r_tx <= w_tx_from_new ? w_new_frame : r_pend;
            r_frame_rdy <= w_load_tx;
        end
    end

    assign bus.tx        = r_tx;
    assign bus.frame_rdy = r_frame_rdy;
    assign bus.slot_idx  = r_slot_idx;
    assign bus.ovf       = r_ovf;
    assign bus.sat       = r_sat;

endmodule

// File: tb/tb_photon_frame_packer.sv
// Directed bench for photon_frame_packer: reset, SS-deferred publication, overwrite,
// saturation, edge coincidence table and a full k-photons-per-slot frame.
module tb_photon_frame_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   rdy_cnt = 0;

    photon_frame_packer_if bus ();

    photon_frame_packer dut (
        .sysClk(clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (bus.frame_rdy === 1'b1) rdy_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int unsigned n;
        bit          at_rise;
        bit          at_fall;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tx_word(input int k);
        logic [8191:0] t;
        t = bus.tx;
        return 32'(t >> (32 * (255 - k)));
    endfunction

    // One gate window with n photons inside, optionally one photon on each gate edge.
    task automatic slot(input int unsigned n, input bit at_rise, input bit at_fall);
        bus.gate = 1'b1; bus.photon = at_rise; tick(1);
        bus.photon = 1'b0; tick(1);
        repeat (n) begin
            bus.photon = 1'b1; tick(1);
            bus.photon = 1'b0; tick(1);
        end
        bus.gate = 1'b0; bus.photon = at_fall; tick(1);
        bus.photon = 1'b0; tick(1);
    endtask

    task automatic empty_slots(input int n);
        repeat (n) slot(0, 1'b0, 1'b0);
    endtask

    task automatic wait_rdy(input string name, input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (bus.frame_rdy === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_vec++;
        if (lat == 0) begin
            n_bad++;
            $display("FAIL %s: frame_rdy not seen within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int lat;
        int rdy0;

        vecs[0] = '{0, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{3, 1'b0, 1'b0, 32'd3};
        vecs[2] = '{0, 1'b1, 1'b0, 32'd1};
        vecs[3] = '{0, 1'b0, 1'b1, 32'd1};
        vecs[4] = '{4, 1'b1, 1'b0, 32'd5};
        vecs[5] = '{5, 1'b1, 1'b1, 32'd7};
        vecs[6] = '{1, 1'b0, 1'b1, 32'd2};
        vecs[7] = '{7, 1'b0, 1'b0, 32'd7};

        bus.photon = 1'b0; bus.gate = 1'b0; bus.SS = 1'b1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_tx_zero",   32'(|bus.tx),     32'd0);
        check("rst_frame_rdy", 32'(bus.frame_rdy), 32'd0);
        check("rst_slot_idx",  32'(bus.slot_idx), 32'd0);
        check("rst_ovf",       32'(bus.ovf),      32'd0);
        check("rst_sat",       32'(bus.sat),      32'd0);

        // Two frames complete while SS is low; the newer one must win on release.
        bus.SS = 1'b0;
        tick(5);
        rdy0 = rdy_cnt;
        slot(1, 1'b0, 1'b0);
        empty_slots(254);
        tick(5);
        check("ssl_ovf_first",  32'(bus.ovf),     32'd0);
        check("ssl_tx_hold_a",  32'(|bus.tx),     32'd0);
        slot(2, 1'b0, 1'b0);
        empty_slots(254);
        tick(5);
        check("ssl_ovf_second", 32'(bus.ovf),     32'd1);
        tick(50);
        check("ssl_tx_hold_b",  32'(|bus.tx),     32'd0);
        check("ssl_no_rdy",     32'(rdy_cnt - rdy0), 32'd0);
        bus.SS = 1'b1;
        wait_rdy("ss_release_rdy", 10, lat);
        check("ss_release_lat", 32'((lat >= 2) && (lat <= 3)), 32'd1);
        check("ovf_hdr",   tx_word(0), 32'hA5C3_0001);
        check("ovf_word1", tx_word(1), 32'd2);
        check("ovf_word2", tx_word(2), 32'd0);
        tick(3);
        check("ovf_one_pulse", 32'(rdy_cnt - rdy0), 32'd1);

        // Saturation: preload the counter near all-ones inside a window.
        bus.gate = 1'b1;
        tick(4);
        force dut.r_count = 32'hFFFF_FFFE;
        tick(1);
        release dut.r_count;
        check("sat_before", 32'(bus.sat), 32'd0);
        repeat (3) begin
            bus.photon = 1'b1; tick(1);
            bus.photon = 1'b0; tick(1);
        end
        bus.gate = 1'b0; tick(2);
        empty_slots(254);
        wait_rdy("sat_frame_rdy", 20, lat);
        check("sat_flag",  32'(bus.sat), 32'd1);
        check("sat_hdr",   tx_word(0), 32'hA5C3_0002);
        check("sat_word1", tx_word(1), 32'hFFFF_FFFF);

        // Edge-coincidence table applied to the first slots of one frame.
        foreach (vecs[i]) slot(vecs[i].n, vecs[i].at_rise, vecs[i].at_fall);
        tick(3);
        check("tbl_slot_idx", 32'(bus.slot_idx), 32'd8);
        empty_slots(255 - 8);
        wait_rdy("tbl_frame_rdy", 20, lat);
        check("tbl_hdr", tx_word(0), 32'hA5C3_0003);
        foreach (vecs[i]) check($sformatf("tbl_word%0d", i + 1), tx_word(i + 1), vecs[i].exp);

        // Reset in the middle of a frame.
        empty_slots(10);
        tick(3);
        check("mid_slot_idx", 32'(bus.slot_idx), 32'd10);
        check("mid_tx_nz",    32'(|bus.tx),      32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_tx",       32'(|bus.tx),       32'd0);
        check("mid_rst_slot_idx", 32'(bus.slot_idx),  32'd0);
        check("mid_rst_ovf",      32'(bus.ovf),       32'd0);
        check("mid_rst_sat",      32'(bus.sat),       32'd0);
        check("mid_rst_rdy",      32'(bus.frame_rdy), 32'd0);
        tick(4);

        // Full frame: slot k carries k photons; seq restarted at 0.
        for (int k = 0; k < 255; k++) slot(k, 1'b0, 1'b0);
        wait_rdy("full_frame_rdy", 20, lat);
        check("full_hdr", tx_word(0), 32'hA5C3_0000);
        for (int k = 0; k < 255; k++) check($sformatf("full_word%0d", k + 1), tx_word(k + 1), 32'(k));
        check("full_ovf", 32'(bus.ovf), 32'd0);
        check("full_sat", 32'(bus.sat), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
